// File: rtl/pkt_wrr_arbiter_avlstrm_pkg.sv
// Shared constants and helpers for the egress packet arbiter and its neighbours.
// Holds the Avalon-ST widths, the weight width and the egress packet stats register address.
package pkt_wrr_arbiter_avlstrm_pkg;

  localparam int AVL_DATA_W   = 512;
  localparam int AVL_EMPTY_W  = 6;
  localparam int AVL_WEIGHT_W = 4;
  localparam int IDX_W        = 3;

  localparam logic [15:0] REG_EGR_PKT = 16'h0040;

  // Advance a source index by one, wrapping at n sources.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx, input int n);
    return (int'(idx) == n - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/pkt_wrr_arbiter_avlstrm_rr_pick.sv
// Rotate-priority encoder: first set request at or after ptr (mod N).
// Produces the one-hot grant, its index and whether any request won.
module rr_pick #(
  parameter int N     = 5,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/pkt_wrr_arbiter_avlstrm.sv
// Packet-atomic weighted round-robin merge of N Avalon-ST sources onto one egress stream.
// Datapath is a combinational mux of the selected source; only grant/credit state is registered.
module pkt_wrr_arbiter_avlstrm
  import pkt_wrr_arbiter_avlstrm_pkg::*;
#(
  parameter int N_IN     = 5,
  parameter int DATA_W   = AVL_DATA_W,
  parameter int EMPTY_W  = AVL_EMPTY_W,
  parameter int WEIGHT_W = AVL_WEIGHT_W
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic [N_IN*DATA_W-1:0]   in_data,
  input  logic [N_IN-1:0]          in_valid,
  input  logic [N_IN-1:0]          in_sop,
  input  logic [N_IN-1:0]          in_eop,
  input  logic [N_IN*EMPTY_W-1:0]  in_empty,
  output logic [N_IN-1:0]          in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [EMPTY_W-1:0]       out_empty,
  output logic                     out_valid,
  output logic                     out_sop,
  output logic                     out_eop,
  input  logic                     out_ready,
  input  logic [N_IN*WEIGHT_W-1:0] cfg_weight,
  output logic [2:0]               grant_idx,
  output logic                     locked,
  output logic [31:0]              out_pkt_cnt,
  output logic                     err_nosop
);

  logic                lock;
  logic [IDX_W-1:0]    gidx;
  logic [IDX_W-1:0]    rr_ptr;
  logic [WEIGHT_W-1:0] credit;

  logic [N_IN-1:0]     elig;
  logic [N_IN-1:0]     nosop;
  logic [N_IN-1:0]     gidx_oh;
  logic [N_IN-1:0]     win_gnt;
  logic [IDX_W-1:0]    win_idx;
  logic                win_any;
  logic [IDX_W-1:0]    sel;
  logic                v_sel;
  logic [WEIGHT_W-1:0] w_sel;
  logic                acc;
  logic                sop_acc;
  logic                eop_acc;
  logic [WEIGHT_W-1:0] credit_nx;
  logic [IDX_W-1:0]    rr_nx;

  always_comb begin
    elig    = '0;
    nosop   = '0;
    gidx_oh = '0;
    for (int i = 0; i < N_IN; i++) begin
      elig[i]    = in_valid[i] & in_sop[i] & (cfg_weight[i*WEIGHT_W +: WEIGHT_W] != '0);
      nosop[i]   = in_valid[i] & ~in_sop[i] & (cfg_weight[i*WEIGHT_W +: WEIGHT_W] != '0);
      gidx_oh[i] = (gidx == IDX_W'(i));
    end
  end

  rr_pick #(.N(N_IN), .IDX_W(IDX_W)) u_pick (
    .req (elig),
    .ptr (rr_ptr),
    .gnt (win_gnt),
    .idx (win_idx),
    .any (win_any)
  );

  assign sel = lock ? gidx : win_idx;

  always_comb begin
    out_data  = '0;
    out_empty = '0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    v_sel     = 1'b0;
    w_sel     = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (sel == IDX_W'(i)) begin
        out_data  = in_data[i*DATA_W +: DATA_W];
        out_empty = in_empty[i*EMPTY_W +: EMPTY_W];
        out_sop   = in_sop[i];
        out_eop   = in_eop[i];
        v_sel     = in_valid[i];
        w_sel     = cfg_weight[i*WEIGHT_W +: WEIGHT_W];
      end
    end
  end

  // Outputs are held quiet while reset is asserted so nothing is accepted then.
  assign out_valid = Rst_n & v_sel & (lock | win_any);
  assign in_ready  = Rst_n ? ((lock ? gidx_oh : win_gnt) & {N_IN{out_ready}}) : '0;

  assign acc     = out_valid & out_ready;
  assign sop_acc = acc & ~lock & out_sop;
  assign eop_acc = acc & out_eop;

  // Credit update on sop first; the eop pointer advance then sees the updated credit.
  always_comb begin
    credit_nx = credit;
    rr_nx     = rr_ptr;
    if (sop_acc) begin
      if (sel != rr_ptr) begin
        rr_nx     = sel;
        credit_nx = w_sel - 1'b1;
      end else if (credit == '0) begin
        credit_nx = w_sel - 1'b1;
      end else begin
        credit_nx = credit - 1'b1;
      end
    end
    if (eop_acc && credit_nx == '0)
      rr_nx = wrap_inc(sel, N_IN);
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      lock        <= 1'b0;
      gidx        <= '0;
      rr_ptr      <= '0;
      credit      <= '0;
      out_pkt_cnt <= '0;
      err_nosop   <= 1'b0;
    end else begin
      rr_ptr <= rr_nx;
      credit <= credit_nx;
      if (sop_acc && !out_eop) begin
        lock <= 1'b1;
        gidx <= sel;
      end else if (eop_acc) begin
        lock <= 1'b0;
      end
      if (eop_acc)
        out_pkt_cnt <= out_pkt_cnt + 32'd1;
      if (!lock && (nosop != '0))
        err_nosop <= 1'b1;
    end
  end

  assign locked    = lock;
  assign grant_idx = gidx;

endmodule

// File: doc/pkt_wrr_arbiter_avlstrm.md
Name: pkt_wrr_arbiter_avlstrm

Overview:
- Packet-atomic weighted round-robin arbiter merging N Avalon-ST packet streams onto the single Ethernet egress stream.
- Replaces the fixed cascade of 3-input muxes on the egress path and adds programmable per-source bandwidth shares.
- Datapath is zero-latency pass-through of the granted source.
- The block owns grant sequencing, per-source credits and egress packet counting.

Parameters:
- N_IN, 5: number of requesting streams (2..8).
- DATA_W, 512: beat width.
- EMPTY_W, 6: empty field width.
- WEIGHT_W, 4: per-source weight width (packets per round).

Ports:
- Clk  in  1  clock.
- Rst_n  in  1  reset, synchronous, active-low.
- in_data  in  N_IN*DATA_W  source beats; source i at slice i.
- in_valid / in_sop / in_eop  in  N_IN each  per-source framing.
- in_empty  in  N_IN*EMPTY_W  per-source empty.
- in_ready  out  N_IN  per-source backpressure.
- out_data / out_empty  out  DATA_W / EMPTY_W  egress beat.
- out_valid / out_sop / out_eop  out  1 each  egress framing.
- out_ready  in  1  egress backpressure.
- cfg_weight  in  N_IN*WEIGHT_W  per-source weight; 0 = source disabled.
- grant_idx  out  3  index of currently locked source (valid when locked=1).
- locked  out  1  a multi-beat packet is in flight.
- out_pkt_cnt  out  32  packets completed on egress (eop&valid&ready), wraps.
- err_nosop  out  1  sticky: a source presented valid without sop while eligible for arbitration.

Behaviour:
- State: lock (1b), gidx, rr_ptr, credit (WEIGHT_W), out_pkt_cnt, err_nosop.
- Reset: lock=0, rr_ptr=0, gidx=0, credit=0, out_pkt_cnt=0, err_nosop=0.
- Reset outputs: out_valid=0, in_ready=0, locked=0, grant_idx=0.
- Reset mid-packet discards the lock; the next cycle arbitrates fresh.
- Eligibility (lock=0): source i eligible iff in_valid[i] & in_sop[i] & cfg_weight[i]!=0.
- Selection: first eligible index scanning rr_ptr, rr_ptr+1, ... mod N_IN, combinational in the same cycle.
- Selected source sel = gidx when lock=1, else the scan winner.
- No winner: out_valid=0.
- Datapath: out_* = in_*[sel]; out_valid = in_valid[sel] & (lock | winner exists).
- in_ready[sel] = out_ready; all other in_ready = 0.
- Zero-cycle latency; a combinational path out_ready -> in_ready is permitted.
- Accept = out_valid & out_ready.
- Lock: on an accepted sop beat without eop, set lock=1, gidx=sel. On an accepted eop beat, lock=0.
- Single-beat packet (sop&eop): never locks.
- While locked, only gidx is served regardless of other requests.
- In-flight sop on the locked source is not checked; the source is trusted.
- Credits, applied on an accepted sop beat from source p:
  - p != rr_ptr: rr_ptr=p, credit=cfg_weight[p]-1.
  - p == rr_ptr and credit==0: credit=cfg_weight[p]-1 (new round).
  - Otherwise: credit=credit-1.
- Credits, applied on an accepted eop beat: if credit==0, rr_ptr=(gidx+1) mod N_IN. Otherwise rr_ptr stays (same source keeps priority).
- For single-beat packets, the sop and eop updates apply in the same cycle: credit logic first, then the eop pointer advance using the new credit.
- cfg_weight is sampled only at credit load.
  - Changes mid-round take effect at the next load.
  - Setting a locked source's weight to 0 does not abort its packet.
- err_nosop sets when lock=0 and some in_valid[i] & !in_sop[i] & cfg_weight[i]!=0. That source is never granted until it shows sop. The flag clears only on reset.
- out_pkt_cnt increments by 1 on accepted eop, wrapping 0xFFFFFFFF -> 0.
- Back-to-back packets: an eop-accept cycle releases the lock. Arbitration for the next packet happens in the following cycle, giving a 1-cycle-min inter-packet bubble only if the new winner's sop would otherwise coincide. A new sop in the same cycle is not allowed.

Decomposition:
- Shared package:
  - Avalon-ST width constants (DATA_W=512, EMPTY_W=6).
  - Weight width.
  - A stats register address constant REG_EGR_PKT for later attachment to the stats packer.
- One sub-module: rr_pick (N-bit request, pointer -> one-hot grant + index, combinational rotate-priority encoder). Reused by other arbiters.

Test Plan:
- Single source 2 busy, weights all 1, 3-beat packets, out_ready=1:
  - Required: beats pass with 0 latency.
  - Required: locked high for beats 1-2.
  - Required: out_pkt_cnt=3 after 3 packets.
- All 5 sources continuously offering 1-beat packets, weights {1,1,1,1,1}:
  - Required: grant order 0,1,2,3,4,0,...
- Weights {3,1,0,0,0}, sources 0 and 1 saturated:
  - Required: pattern 0,0,0,1,0,0,0,1.
  - Required: sources 2-4 never ready.
- Source 0 mid-packet (4 beats) while source 3 raises sop:
  - Required: source 3 in_ready=0 until source 0 eop accepted, then source 3 granted.
- out_ready toggling 1010 during a locked 5-beat packet:
  - Required: no beat duplicated or dropped.
  - Required: in_ready mirrors out_ready only on gidx.
- Source 4 valid without sop while idle:
  - Required: err_nosop=1 and stays set.
  - Required: Rst_n low mid-packet clears lock, counters and the flag next cycle.
